fc_load_sequencer: RTL and testbench
====================================

Name: fc_load_sequencer

Overview:
- Controller that sequences one fully-connected layer pass end to end:
  - fetches the input vector, NUM_OUT weight rows and the bias vector from the wide FC memory (one LANES×DATA_W word per address);
  - streams them into the layer's register banks;
  - pulses the layer start and waits for the layer to finish;
  - writes the NUM_OUT results back to memory one word per cycle.
- Sits between the FC memory and the fc_layer instance in the FC top.
- Sole owner of the memory port while busy.

Parameters:
- DATA_W, 16, width of one element (fixed-point).
- LANES, 120, elements per memory read word; must be ≥ NUM_IN and ≥ NUM_OUT.
- NUM_IN, 120, layer input count.
- NUM_OUT, 84, layer output count; also the number of weight rows.
- ADDR_W, 14, memory address width.
- BASE_ADDR, 0, address of the input vector. Weight row r is at BASE_ADDR+1+r. Biases are at BASE_ADDR+NUM_OUT+1.
- OUT_BASE, 10200, first writeback address. Output k is written to OUT_BASE+k.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when writeback completes
- mem_rd_en  out  1  read strobe; data returns exactly one cycle later
- mem_wr_en  out  1  write strobe
- mem_addr  out  ADDR_W  read/write address
- mem_rd_data  in  LANES*DATA_W  read word; lane i occupies bits [i*DATA_W +: DATA_W]
- mem_wr_data  out  DATA_W  writeback element
- row_wr_en  out  1  load strobe into the layer banks
- row_wr_sel  out  2  0 = input, 1 = weight row, 2 = bias
- row_wr_idx  out  $clog2(NUM_OUT)  weight row index; 0 for input and bias
- row_wr_data  out  LANES*DATA_W  registered copy of mem_rd_data
- layer_start  out  1  one-cycle enable pulse to fc_layer
- layer_done  in  1  fc_layer finished (level or pulse)
- out_idx  out  $clog2(NUM_OUT)  output element selector into fc_layer
- out_data  in  DATA_W  fc_layer output[out_idx], combinational

Behaviour:
- Reset: state = IDLE; all outputs 0, including all buses.
- Reset mid-operation aborts immediately with no further memory or layer activity.
- States: IDLE, LOAD, DRAIN, RUN, WAIT, WB, FIN.
- IDLE:
  - start=1 → LOAD; clear rd_cnt.
  - start is ignored in all other states (no queuing).
- LOAD:
  - Each cycle: mem_rd_en=1, mem_addr=BASE_ADDR+rd_cnt, rd_cnt++.
  - After rd_cnt = NUM_OUT+1 is issued → DRAIN.
  - Total reads: NUM_OUT+2.
- Read return (one cycle after each issue): row_wr_en=1 with row_wr_data=mem_rd_data, tagged from the delayed rd_cnt:
  - tag 0 → sel 0;
  - tags 1..NUM_OUT → sel 1, idx = tag-1;
  - tag NUM_OUT+1 → sel 2.
- DRAIN: one cycle; the last row_wr_en is issued here → RUN.
- RUN: layer_start=1 for exactly one cycle → WAIT.
- WAIT:
  - layer_done=1 → WB, wb_cnt=0.
  - layer_done is sampled only in WAIT; no timeout.
- WB:
  - out_idx=wb_cnt, mem_wr_en=1, mem_addr=OUT_BASE+wb_cnt, mem_wr_data=out_data (same cycle).
  - After wb_cnt = NUM_OUT-1 → FIN.
- FIN: done=1 for one cycle → IDLE; busy falls in the same cycle done falls.
- Exclusivity: mem_rd_en and mem_wr_en are never high together. Only these outputs are non-zero outside their active states:
  - mem_addr, row_wr_data and out_idx hold their last value;
  - all strobes are 0.
- Latency (start sampled at edge 0, NUM_OUT=84):
  - reads on cycles 1..86;
  - row writes on cycles 2..87;
  - layer_start on cycle 88;
  - writeback takes 84 cycles after layer_done is seen;
  - done one cycle after the last write.
- Widths:
  - Counters are sized for NUM_OUT+2 and never wrap.
  - Address arithmetic is unsigned, ADDR_W bits.
  - The elaboration check OUT_BASE+NUM_OUT ≤ 2^ADDR_W is enforced.

Decomposition:
- Package fc_pkg:
  - row_sel_e enum (SEL_IN, SEL_W, SEL_B);
  - state enum;
  - DATA_W / LANES defaults;
  - address-map localparams shared with the FC memory initialiser.
- Sub-module fc_rd_tag_pipe: one-stage valid/tag delay that aligns the issued read index with the returning data. Everything else is inline.

Test Plan:
- Reset then idle: all outputs 0, busy=0, no strobes for 20 cycles.
- Full pass with NUM_OUT=84:
  - memory word at address a has lane i = a+i;
  - expect 86 reads at addresses 0..85, then row writes sel 0 idx 0, sel 1 idx 0..83, sel 2;
  - layer_start on cycle 88;
  - stub layer_done after 10 cycles;
  - 84 writes at addresses 10200..10283 with out_data = 0x1000+out_idx;
  - done pulses once.
- start re-asserted during LOAD and during WAIT: ignored; exactly one pass and one done pulse.
- Reset asserted on cycle 40 of LOAD: next cycle all strobes 0 and busy=0; a fresh start then completes a normal pass.
- layer_done held high from cycle 0: no effect until WAIT, then WB begins the cycle after WAIT is entered.
- Small configuration, NUM_OUT=2, BASE_ADDR=5, OUT_BASE=100: reads at 5, 6, 7, 8; writes at 100, 101; mem_rd_en and mem_wr_en are never concurrent.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and address-map defaults for the fully-connected layer slice.
// The FC memory initialiser relies on the same address map.
package fc_pkg;

    typedef enum logic [1:0] {
        SEL_IN = 2'd0,
        SEL_W  = 2'd1,
        SEL_B  = 2'd2
    } row_sel_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_WAIT,
        S_WB,
        S_FIN
    } state_e;

    localparam int unsigned FC_DATA_W    = 16;
    localparam int unsigned FC_LANES     = 120;
    localparam int unsigned FC_NUM_IN    = 120;
    localparam int unsigned FC_NUM_OUT   = 84;
    localparam int unsigned FC_ADDR_W    = 14;
    // Input vector at base, weight row r at base+1+r, biases at base+NUM_OUT+1.
    localparam int unsigned FC_BASE_ADDR = 0;
    localparam int unsigned FC_OUT_BASE  = 10200;

endpackage

// File: rtl/fc_rd_tag_pipe.sv
// One-stage delay of the read strobe and its index, aligning the tag with the
// word the memory returns one cycle after the read is issued.
module fc_rd_tag_pipe #(
    parameter int unsigned TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_tag <= in_tag;
            end
        end
    end

endmodule

// File: rtl/fc_load_sequencer.sv
// Sequences one FC layer pass: load input/weights/bias from the wide memory,
// run the layer, then write the NUM_OUT results back one element per cycle.
module fc_load_sequencer
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W    = FC_DATA_W,
    parameter int unsigned LANES     = FC_LANES,
    parameter int unsigned NUM_IN    = FC_NUM_IN,
    parameter int unsigned NUM_OUT   = FC_NUM_OUT,
    parameter int unsigned ADDR_W    = FC_ADDR_W,
    parameter int unsigned BASE_ADDR = FC_BASE_ADDR,
    parameter int unsigned OUT_BASE  = FC_OUT_BASE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [LANES*DATA_W-1:0]     mem_rd_data,
    output logic [DATA_W-1:0]           mem_wr_data,
    output logic                        row_wr_en,
    output logic [1:0]                  row_wr_sel,
    output logic [$clog2(NUM_OUT)-1:0]  row_wr_idx,
    output logic [LANES*DATA_W-1:0]     row_wr_data,
    output logic                        layer_start,
    input  logic                        layer_done,
    output logic [$clog2(NUM_OUT)-1:0]  out_idx,
    input  logic [DATA_W-1:0]           out_data
);

    localparam int unsigned CNT_W = $clog2(NUM_OUT + 2);
    localparam int unsigned IDX_W = $clog2(NUM_OUT);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(NUM_OUT + 1);
    localparam logic [CNT_W-1:0] LAST_WB = CNT_W'(NUM_OUT - 1);

    if (longint'(OUT_BASE) + longint'(NUM_OUT) > (64'd1 << ADDR_W)) begin : g_bad_out_map
        $error("fc_load_sequencer: writeback window exceeds address space");
    end
    if (LANES < NUM_IN || LANES < NUM_OUT || NUM_OUT < 2) begin : g_bad_shape
        $error("fc_load_sequencer: LANES must cover NUM_IN and NUM_OUT, NUM_OUT >= 2");
    end

    state_e                   state, state_nx;
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic [ADDR_W-1:0]        addr_q;
    logic [IDX_W-1:0]         out_idx_q;
    logic [LANES*DATA_W-1:0]  row_hold_q;
    logic                     tag_valid;
    logic [CNT_W-1:0]         tag;

    fc_rd_tag_pipe #(
        .TAG_W (CNT_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mem_rd_en),
        .in_tag    (cnt),
        .out_valid (tag_valid),
        .out_tag   (tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            out_idx_q  <= '0;
            row_hold_q <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            addr_q    <= mem_addr;
            out_idx_q <= out_idx;
            if (tag_valid) begin
                row_hold_q <= mem_rd_data;
            end
        end
    end

    // One counter serves both read issue and writeback; it saturates at the last read.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = addr_q;
        mem_wr_data = '0;
        layer_start = 1'b0;
        out_idx     = out_idx_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    cnt_nx   = '0;
                end
            end
            S_LOAD: begin
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
                if (cnt == LAST_RD) begin
                    state_nx = S_DRAIN;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: state_nx = S_RUN;
            S_RUN: begin
                layer_start = 1'b1;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                if (layer_done) begin
                    state_nx = S_WB;
                    cnt_nx   = '0;
                end
            end
            S_WB: begin
                mem_wr_en   = 1'b1;
                out_idx     = IDX_W'(cnt);
                mem_addr    = ADDR_W'(OUT_BASE) + ADDR_W'(cnt);
                mem_wr_data = out_data;
                if (cnt == LAST_WB) begin
                    state_nx = S_FIN;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Returned word goes straight to the banks on its strobe and is held afterwards.
    always_comb begin
        row_wr_en   = tag_valid;
        row_wr_sel  = '0;
        row_wr_idx  = '0;
        row_wr_data = tag_valid ? mem_rd_data : row_hold_q;
        if (tag_valid) begin
            if (tag == '0) begin
                row_wr_sel = SEL_IN;
            end else if (tag == LAST_RD) begin
                row_wr_sel = SEL_B;
            end else begin
                row_wr_sel = SEL_W;
                row_wr_idx = IDX_W'(tag - CNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_fc_load_sequencer.sv
// Scoreboard bench: full-size sequencer plus a small NUM_OUT=2 instance.
module tb_fc_load_sequencer;
    import fc_pkg::*;

    localparam int DW = 16;
    localparam int LN = 120;
    localparam int WW = DW * LN;

    typedef struct {
        int sel;
        int idx;
        int addr;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic ld0 = 1'b0, ld1 = 1'b0;

    logic busy0, done0, rd0, wr0, row_en0, ls0;
    logic [13:0] addr0;
    logic [15:0] wdata0, odata0;
    logic [1:0] sel0;
    logic [6:0] idx0, oidx0;
    logic [WW-1:0] rowd0, mrd0 = '0;

    logic busy1, done1, rd1, wr1, row_en1, ls1;
    logic [13:0] addr1;
    logic [15:0] wdata1, odata1;
    logic [1:0] sel1;
    logic [0:0] idx1, oidx1;
    logic [WW-1:0] rowd1, mrd1 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0[2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int ld_mode[2] = '{0, 0};
    int ld_cd[2] = '{0, 0};

    int   exp_rd[2][$];
    row_t exp_row[2][$];
    int   exp_wa[2][$];
    int   exp_wd[2][$];
    int   exp_ls[2][$];
    int   exp_done[2][$];

    fc_load_sequencer u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .mem_rd_en(rd0), .mem_wr_en(wr0), .mem_addr(addr0), .mem_rd_data(mrd0),
        .mem_wr_data(wdata0), .row_wr_en(row_en0), .row_wr_sel(sel0), .row_wr_idx(idx0),
        .row_wr_data(rowd0), .layer_start(ls0), .layer_done(ld0), .out_idx(oidx0),
        .out_data(odata0)
    );

    fc_load_sequencer #(
        .NUM_OUT   (2),
        .BASE_ADDR (5),
        .OUT_BASE  (100)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .mem_rd_en(rd1), .mem_wr_en(wr1), .mem_addr(addr1), .mem_rd_data(mrd1),
        .mem_wr_data(wdata1), .row_wr_en(row_en1), .row_wr_sel(sel1), .row_wr_idx(idx1),
        .row_wr_data(rowd1), .layer_start(ls1), .layer_done(ld1), .out_idx(oidx1),
        .out_data(odata1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WW-1:0] mkword(int a);
        logic [WW-1:0] w;
        for (int i = 0; i < LN; i++) w[i*DW +: DW] = DW'(a + i);
        return w;
    endfunction

    function automatic int p_no(int u);   return (u == 0) ? 84 : 2;      endfunction
    function automatic int p_base(int u); return (u == 0) ? 0 : 5;       endfunction
    function automatic int p_ob(int u);   return (u == 0) ? 10200 : 100; endfunction

    always @(posedge clk) begin
        if (rd0) mrd0 <= mkword(int'(addr0));
        if (rd1) mrd1 <= mkword(int'(addr1));
    end
    assign odata0 = 16'h1000 + 16'(oidx0);
    assign odata1 = 16'h1000 + 16'(oidx1);

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic unexp(string nm, longint act);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event value %0d required none", nm, act);
    endtask

    task automatic mon(int u, logic rd, logic wr, int addr, int wd, logic ren, int sel,
                       int idx, logic [WW-1:0] rowd, logic ls, logic dn);
        int rel;
        row_t r;
        logic [WW-1:0] ew;
        rel = cyc - t0[u] + 1;
        if (rd || wr) chk($sformatf("u%0d rd_wr_overlap", u), longint'(rd && wr), 0);
        if (rd) begin
            if (exp_rd[u].size() == 0) unexp($sformatf("u%0d read", u), addr);
            else chk($sformatf("u%0d rd_addr", u), addr, exp_rd[u].pop_front());
        end
        if (ren) begin
            if (exp_row[u].size() == 0) unexp($sformatf("u%0d row_wr", u), sel);
            else begin
                r = exp_row[u].pop_front();
                chk($sformatf("u%0d row_sel", u), sel, r.sel);
                chk($sformatf("u%0d row_idx", u), idx, r.idx);
                ew = mkword(r.addr);
                checks++;
                if (rowd !== ew) begin
                    errors++;
                    $display("FAIL u%0d row_data: got lane0 %0h lane1 %0h required lane0 %0h lane1 %0h",
                             u, rowd[15:0], rowd[31:16], ew[15:0], ew[31:16]);
                end
            end
        end
        if (wr) begin
            if (exp_wa[u].size() == 0) unexp($sformatf("u%0d write", u), addr);
            else begin
                chk($sformatf("u%0d wr_addr", u), addr, exp_wa[u].pop_front());
                chk($sformatf("u%0d wr_data", u), wd, exp_wd[u].pop_front());
            end
        end
        if (ls) begin
            if (exp_ls[u].size() == 0) unexp($sformatf("u%0d layer_start", u), rel);
            else chk($sformatf("u%0d layer_start_cycle", u), rel, exp_ls[u].pop_front());
            if (ld_mode[u] == 0) ld_cd[u] = 11;
            else exp_done[u].push_back(rel + p_no(u) + 2);
        end
        if (dn) begin
            done_cnt[u]++;
            if (exp_done[u].size() == 0) unexp($sformatf("u%0d done", u), rel);
            else chk($sformatf("u%0d done_cycle", u), rel, exp_done[u].pop_front());
        end
    endtask

    // Monitor first, then the layer_done stub for each instance.
    always @(negedge clk) begin
        mon(0, rd0, wr0, int'(addr0), int'(wdata0), row_en0, int'(sel0), int'(idx0), rowd0, ls0, done0);
        mon(1, rd1, wr1, int'(addr1), int'(wdata1), row_en1, int'(sel1), int'(idx1), rowd1, ls1, done1);
        if (ld_cd[0] > 0) begin
            ld_cd[0]--;
            if (ld_cd[0] == 0) begin
                ld0 = 1'b1;
                exp_done[0].push_back(cyc - t0[0] + 1 + p_no(0) + 1);
            end
        end else if (ld_mode[0] == 0) ld0 = 1'b0;
        if (ld_cd[1] > 0) begin
            ld_cd[1]--;
            if (ld_cd[1] == 0) begin
                ld1 = 1'b1;
                exp_done[1].push_back(cyc - t0[1] + 1 + p_no(1) + 1);
            end
        end else if (ld_mode[1] == 0) ld1 = 1'b0;
    end

    task automatic push_reads_rows(int u, int nrd, int nrow);
        int no, b;
        row_t r;
        no = p_no(u);
        b  = p_base(u);
        for (int a = 0; a < nrd; a++) exp_rd[u].push_back(b + a);
        for (int t = 0; t < nrow; t++) begin
            if (t == 0) r = '{0, 0, b};
            else if (t == no + 1) r = '{2, 0, b + no + 1};
            else r = '{1, t - 1, b + t};
            exp_row[u].push_back(r);
        end
    endtask

    task automatic push_pass(int u);
        int no;
        no = p_no(u);
        push_reads_rows(u, no + 2, no + 2);
        exp_ls[u].push_back(no + 4);
        for (int k = 0; k < no; k++) begin
            exp_wa[u].push_back(p_ob(u) + k);
            exp_wd[u].push_back('h1000 + k);
        end
    endtask

    task automatic issue_start(int u);
        @(negedge clk);
        if (u == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        t0[u] = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(int u, int prev, int budget);
        for (int i = 0; i < budget && done_cnt[u] == prev; i++) @(negedge clk);
        if (done_cnt[u] == prev) unexp($sformatf("u%0d done_timeout", u), budget);
        @(negedge clk);
        chk($sformatf("u%0d busy_after_done", u), longint'(u == 0 ? busy0 : busy1), 0);
        chk($sformatf("u%0d done_count", u), done_cnt[u], prev + 1);
    endtask

    task automatic chk_drained(int u);
        chk($sformatf("u%0d reads_left", u), exp_rd[u].size(), 0);
        chk($sformatf("u%0d rows_left", u), exp_row[u].size(), 0);
        chk($sformatf("u%0d writes_left", u), exp_wa[u].size(), 0);
        chk($sformatf("u%0d starts_left", u), exp_ls[u].size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: every output zero.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_strobes", {busy0, done0, rd0, wr0, row_en0, ls0, sel0}, 0);
            chk("idle_addr", addr0, 0);
            chk("idle_wdata_idx", {wdata0, idx0, oidx0}, 0);
            chk("idle_row_data", longint'(|rowd0), 0);
            chk("idle_small", {busy1, done1, rd1, wr1, row_en1, ls1, addr1, idx1, oidx1}, 0);
        end

        // Plain full pass.
        push_pass(0);
        issue_start(0);
        wait_done(0, 0, 400);
        chk_drained(0);

        // start re-asserted during LOAD and during WAIT must be ignored.
        push_pass(0);
        issue_start(0);
        repeat (18) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 200 && exp_ls[0].size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 1, 400);
        repeat (20) @(negedge clk);
        chk("u0 single_done_after_restarts", done_cnt[0], 2);
        chk_drained(0);

        // Reset during cycle 40 of LOAD: 40 reads, 39 row writes, then silence.
        push_reads_rows(0, 40, 39);
        issue_start(0);
        repeat (39) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy0, 0);
        chk("abort_strobes", {rd0, wr0, row_en0, ls0, done0}, 0);
        chk_drained(0);
        repeat (5) @(negedge clk);
        push_pass(0);
        issue_start(0);
        wait_done(0, 2, 400);
        chk_drained(0);

        // layer_done held high throughout: only acted on in WAIT.
        ld_mode[0] = 1;
        ld0 = 1'b1;
        push_pass(0);
        issue_start(0);
        wait_done(0, 3, 400);
        ld0 = 1'b0;
        ld_mode[0] = 0;
        chk_drained(0);

        // Small configuration.
        push_pass(1);
        issue_start(1);
        wait_done(1, 0, 100);
        chk_drained(1);
        chk("u0 no_extra_done", done_cnt[0], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
